// File: rtl/if_fetch_stage.sv
// IF stage: PC register, single-outstanding imem fetch, IF/ID register; 1 instr/cycle at 1-cycle imem latency.
// Stall freezes PC/IF-ID and parks a returning response in a hold buffer; IF_FETCH_PERF_EN adds fetch/flush counters.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        pc_src_i,
  input  logic [31:0] pc_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        ifid_valid_o,
  output logic [31:0] ifid_pc_o,
  output logic [31:0] ifid_pc_plus4_o,
`ifdef IF_FETCH_PERF_EN
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
`endif
  output logic [31:0] ifid_instr_o
);

  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] hold_q;
  logic        ifid_valid_q;
  logic [31:0] ifid_pc_q;
  logic [31:0] ifid_pc4_q;
  logic [31:0] ifid_instr_q;

  logic        req;
  logic        load;
  logic        capture;
  logic [31:0] load_instr;
  logic        unused_tgt_bits;

  assign pc_plus4        = pc_q + 32'd4;
  assign unused_tgt_bits = ^pc_target_i[1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_ISSUE;
    else        state_q <= state_d;
  end

  // Next-state logic; a redirect overrides stall and any response
  always_comb begin
    state_d = state_q;
    if (pc_src_i) begin
      if (state_q == S_WAIT || state_q == S_DRAIN)
        state_d = imem_rvalid_i ? S_ISSUE : S_DRAIN;
      else
        state_d = S_ISSUE;
    end else begin
      case (state_q)
        S_ISSUE: if (!stall_i) state_d = S_WAIT;
        S_WAIT:  if (imem_rvalid_i && stall_i) state_d = S_HOLD;
        S_HOLD:  if (!stall_i) state_d = S_WAIT;
        S_DRAIN: if (imem_rvalid_i) state_d = S_ISSUE;
        default: state_d = S_ISSUE;
      endcase
    end
  end

  // Output/control logic; the follow-on request goes out in the load cycle at pc_q+4
  always_comb begin
    req        = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    load_instr = imem_rdata_i;
    imem_addr_o = pc_q;
    case (state_q)
      S_ISSUE: req = !stall_i && !pc_src_i;
      S_WAIT: begin
        imem_addr_o = pc_plus4;
        if (imem_rvalid_i && !pc_src_i) begin
          if (stall_i) begin
            capture = 1'b1;
          end else begin
            load = 1'b1;
            req  = 1'b1;
          end
        end
      end
      S_HOLD: begin
        imem_addr_o = pc_plus4;
        load_instr  = hold_q;
        if (!stall_i && !pc_src_i) begin
          load = 1'b1;
          req  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign imem_req_o = req && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      hold_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= NOP_INSTR;
    end else if (pc_src_i) begin
      pc_q         <= {pc_target_i[31:2], 2'b00};
      hold_q       <= '0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= NOP_INSTR;
    end else begin
      if (capture) hold_q <= imem_rdata_i;
      if (load) begin
        pc_q         <= pc_plus4;
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= pc_q;
        ifid_pc4_q   <= pc_plus4;
        ifid_instr_q <= load_instr;
      end
    end
  end

  assign ifid_valid_o    = ifid_valid_q;
  assign ifid_pc_o       = ifid_pc_q;
  assign ifid_pc_plus4_o = ifid_pc4_q;
  assign ifid_instr_o    = ifid_valid_q ? ifid_instr_q : NOP_INSTR;

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (load)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (pc_src_i) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = fetch_cnt_q;
  assign perf_flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: bench-driven imem responses, expected IF/ID loads queued at response time.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        pc_src_i;
  logic [31:0] pc_target_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        ifid_valid_o;
  logic [31:0] ifid_pc_o;
  logic [31:0] ifid_pc_plus4_o;
  logic [31:0] ifid_instr_o;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt_o;
  logic [31:0] perf_flush_cnt_o;
`endif

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  if_fetch_stage dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall_i         (stall_i),
    .pc_src_i        (pc_src_i),
    .pc_target_i     (pc_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .ifid_valid_o    (ifid_valid_o),
    .ifid_pc_o       (ifid_pc_o),
    .ifid_pc_plus4_o (ifid_pc_plus4_o),
`ifdef IF_FETCH_PERF_EN
    .perf_fetch_cnt_o(perf_fetch_cnt_o),
    .perf_flush_cnt_o(perf_flush_cnt_o),
`endif
    .ifid_instr_o    (ifid_instr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic st, input logic ps, input logic [31:0] tgt,
                        input logic rv, input logic [31:0] rd);
    stall_i       = st;
    pc_src_i      = ps;
    pc_target_i   = tgt;
    imem_rvalid_i = rv;
    imem_rdata_i  = rd;
    #1;
  endtask

  task automatic expect_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, "_req"}, {31'd0, imem_req_o}, {31'd0, req});
    if (req) chk({tag, "_addr"}, imem_addr_o, addr);
  endtask

  task automatic expect_load(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s observed=load expected=empty_scoreboard", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd1);
      chk({tag, "_pc"},    ifid_pc_o,       e.pc);
      chk({tag, "_pc4"},   ifid_pc_plus4_o, e.pc4);
      chk({tag, "_instr"}, ifid_instr_o,    e.instr);
    end
  endtask

  task automatic check_flush(input string tag, input logic [31:0] held_pc);
    chk({tag, "_valid"}, {31'd0, ifid_valid_o}, 32'd0);
    chk({tag, "_instr"}, ifid_instr_o, NOP);
    chk({tag, "_pc"},    ifid_pc_o,    held_pc);
  endtask

  // One 1-cycle-latency response for the outstanding fetch at pc; follow-on request expected at pc+4
  task automatic resp(input logic [31:0] pc);
    set_in(1'b0, 1'b0, 32'd0, 1'b1, mem(pc));
    expect_req("resp", 1'b1, pc + 32'd4);
    sb.push_back(exp_t'{pc, pc + 32'd4, mem(pc)});
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_load("resp_load");
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    repeat (2) cyc();
    chk("rst_req",   {31'd0, imem_req_o},   32'd0);
    chk("rst_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rst_pc",    ifid_pc_o,       32'd0);
    chk("rst_pc4",   ifid_pc_plus4_o, 32'd0);
    chk("rst_instr", ifid_instr_o,    NOP);

    // T1: first fetch and back-to-back streaming
    rst_n = 1'b1;
    #1;
    expect_req("t1_first", 1'b1, 32'h0);
    cyc();
    resp(32'h0);
    resp(32'h4);
    resp(32'h8);

    // T2: stall as the response for 0xC returns, held 3 cycles
    set_in(1'b1, 1'b0, 32'd0, 1'b1, 32'h0050_0093);
    expect_req("t2_cap", 1'b0, 32'd0);
    sb.push_back(exp_t'{32'hC, 32'h10, 32'h0050_0093});
    cyc();
    chk("t2_hold1_pc", ifid_pc_o, 32'h8);
    chk("t2_hold1_valid", {31'd0, ifid_valid_o}, 32'd1);
    set_in(1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_req("t2_hold2", 1'b0, 32'd0);
    cyc();
    chk("t2_hold2_pc", ifid_pc_o, 32'h8);
    expect_req("t2_hold3", 1'b0, 32'd0);
    cyc();
    chk("t2_hold3_instr", ifid_instr_o, mem(32'h8));
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    expect_req("t2_release", 1'b1, 32'h10);
    cyc();
    expect_load("t2_load");

    // T3: redirect while waiting, late response discarded
    set_in(1'b0, 1'b1, 32'h100, 1'b0, 32'd0);
    expect_req("t3_redir", 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_flush("t3_flush", 32'hC);
    expect_req("t3_drain1", 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
    expect_req("t3_drain2", 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_flush("t3_discard", 32'hC);
    expect_req("t3_issue", 1'b1, 32'h100);
    cyc();
    resp(32'h100);

    // T4: redirect together with rvalid and stall, unaligned target
    set_in(1'b1, 1'b1, 32'h203, 1'b1, mem(32'h104));
    expect_req("t4_redir", 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_flush("t4_flush", 32'h100);
    expect_req("t4_issue", 1'b1, 32'h200);
    cyc();
    resp(32'h200);

    // T5: PC wraps past the top of the address space
    set_in(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, mem(32'h204));
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    check_flush("t5_flush", 32'h200);
    expect_req("t5_issue", 1'b1, 32'hFFFF_FFFC);
    cyc();
    resp(32'hFFFF_FFFC);
    resp(32'h0);

    // Reset in the middle of an outstanding fetch
    rst_n = 1'b0;
    #1;
    chk("rst2_req",   {31'd0, imem_req_o},   32'd0);
    chk("rst2_valid", {31'd0, ifid_valid_o}, 32'd0);
    chk("rst2_instr", ifid_instr_o, NOP);
    rst_n = 1'b1;
    #1;
    expect_req("rst2_first", 1'b1, 32'h0);
    cyc();

`ifdef IF_FETCH_PERF_EN
    // T6: performance counters
    chk("t6_fetch0", perf_fetch_cnt_o, 32'd0);
    chk("t6_flush0", perf_flush_cnt_o, 32'd0);
    for (int i = 0; i < 5; i++) resp(32'(i * 4));
    set_in(1'b0, 1'b1, 32'h40, 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b1, 32'h80, 1'b0, 32'd0);
    cyc();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    chk("t6_fetch5", perf_fetch_cnt_o, 32'd5);
    chk("t6_flush2", perf_flush_cnt_o, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("t6_fetch_rst", perf_fetch_cnt_o, 32'd0);
    chk("t6_flush_rst", perf_flush_cnt_o, 32'd0);
    rst_n = 1'b1;
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
